// File: rtl/vga_mode_scheduler_if.sv
// Mode-request handshake and pixel bus between the video timing side and the scheduler.
// master drives timing/request inputs; slave (the scheduler) drives ready/ack/mode/rgb.
interface vga_mode_scheduler_if;
    logic        frame_tick;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [11:0] sw;
    logic [1:0]  mode_req;
    logic        req_valid;
    logic        req_ready;
    logic        mode_ack;
    logic [1:0]  mode;
    logic [11:0] rgb;

    modport master (
        output frame_tick, video_on, pixel_x, sw, mode_req, req_valid,
        input  req_ready, mode_ack, mode, rgb
    );

    modport slave (
        input  frame_tick, video_on, pixel_x, sw, mode_req, req_valid,
        output req_ready, mode_ack, mode, rgb
    );
endinterface

// File: rtl/vga_mode_scheduler.sv
// Frame-synchronous display mode scheduler; rgb registered with 1-cycle latency.
// Mode requests are held off (req_ready=0) until the next frame_tick; VGA_CYCLE_EN adds the CYCLE mode.
module vga_mode_scheduler #(
    parameter int FRAMES_PER_STEP = 30
) (
    input  logic                 clk,
    input  logic                 rst,
    vga_mode_scheduler_if.slave  bus
);
    localparam logic [1:0] M_SOLID = 2'd0;
    localparam logic [1:0] M_BARS  = 2'd1;
    localparam logic [1:0] M_CYCLE = 2'd2;
    localparam logic [1:0] M_BLANK = 2'd3;

    typedef enum logic {IDLE, ARMED} state_t;

    state_t      state_q, state_d;
    logic [1:0]  latch_q, latch_d;
    logic [1:0]  mode_q, mode_d;
    logic        ack_q, ack_d;
    logic [11:0] rgb_q, rgb_d;
    logic        accept, apply;
    logic [2:0]  bar_k;
    logic [11:0] color;
`ifdef VGA_CYCLE_EN
    logic [7:0]  fcnt_q, fcnt_d;
    logic [2:0]  cidx_q, cidx_d;
`endif

    function automatic logic [11:0] palette(input logic [2:0] i);
        return {{4{i[2]}}, {4{i[1]}}, {4{i[0]}}};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            latch_q <= 2'd0;
            mode_q  <= M_SOLID;
            ack_q   <= 1'b0;
            rgb_q   <= 12'h000;
`ifdef VGA_CYCLE_EN
            fcnt_q  <= 8'd0;
            cidx_q  <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            latch_q <= latch_d;
            mode_q  <= mode_d;
            ack_q   <= ack_d;
            rgb_q   <= rgb_d;
`ifdef VGA_CYCLE_EN
            fcnt_q  <= fcnt_d;
            cidx_q  <= cidx_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid)  state_d = ARMED;
            ARMED:   if (bus.frame_tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state_q == IDLE);
        accept        = (state_q == IDLE)  && bus.req_valid;
        apply         = (state_q == ARMED) && bus.frame_tick;
    end

    always_comb begin
        latch_d = accept ? bus.mode_req : latch_q;
        ack_d   = apply;
        mode_d  = mode_q;
        if (apply) begin
`ifdef VGA_CYCLE_EN
            mode_d = latch_q;
`else
            mode_d = (latch_q == M_CYCLE) ? M_SOLID : latch_q;
`endif
        end
    end

    // Bar index is the number of 80-pixel boundaries at or left of pixel_x; saturates at 7.
    always_comb begin
        bar_k = 3'd0;
        for (int j = 1; j < 8; j++) begin
            if (bus.pixel_x >= 10'(j * 80)) bar_k = bar_k + 3'd1;
        end
    end

    always_comb begin
        color = 12'h000;
        case (mode_q)
            M_SOLID: color = bus.sw;
            M_BARS:  color = palette(bar_k);
`ifdef VGA_CYCLE_EN
            M_CYCLE: color = palette(cidx_q);
`else
            M_CYCLE: color = bus.sw;
`endif
            M_BLANK: color = 12'h000;
            default: color = 12'h000;
        endcase
        rgb_d = bus.video_on ? color : 12'h000;
    end

`ifdef VGA_CYCLE_EN
    // Applying CYCLE restarts the sequence even if CYCLE was already active.
    always_comb begin
        fcnt_d = fcnt_q;
        cidx_d = cidx_q;
        if (mode_q == M_CYCLE && bus.frame_tick) begin
            if (fcnt_q == 8'(FRAMES_PER_STEP - 1)) begin
                fcnt_d = 8'd0;
                cidx_d = cidx_q + 3'd1;
            end else begin
                fcnt_d = fcnt_q + 8'd1;
            end
        end
        if (apply && latch_q == M_CYCLE) begin
            fcnt_d = 8'd0;
            cidx_d = 3'd0;
        end
    end
`endif

    assign bus.mode_ack = ack_q;
    assign bus.mode     = mode_q;
    assign bus.rgb      = rgb_q;
endmodule
